// File: rtl/mont_mult_param.sv
// ============================================================================
// mont_mult_param
// ----------------------------------------------------------------------------
// Parametrised radix-2 bit-serial Montgomery multiplier for the lockNET
// RSA/modexp datapath.
//
//     result = a * b * 2^-W mod m
//
// The operands are captured when a request is accepted, so the caller may
// change a/b/m while the core is working. One operand bit of 'a' is consumed
// per ITER cycle. A single conditional subtraction at the end brings the
// accumulator from [0, 2m) into [0, m).
//
// Parameters
//   W       operand/modulus width in bits (Montgomery radix R = 2^W), W >= 4
//   CNT_W   iteration counter width, 2^CNT_W must exceed W
//
// Ports
//   pclk    in   1   clock, rising edge
//   reset   in   1   synchronous, active-high reset
//   start   in   1   request; sampled only in IDLE
//   a       in   W   multiplicand (Montgomery domain, < m)
//   b       in   W   multiplier   (Montgomery domain, < m)
//   m       in   W   modulus (odd)
//   busy    out  1   high in ITER and SUB
//   done    out  1   one-cycle pulse when result is valid
//   result  out  W   a*b*R^-1 mod m, held until a new result is produced
//   err     out  1   operand error flag, valid with done
//
// Build option
//   MONT_MOD_CHECK_EN  when defined, an accepted request is checked for an
//                      even modulus or a/b >= m. A bad request skips the
//                      iterations, pulses done in the next cycle with err=1
//                      and result=0, and never raises busy. When undefined,
//                      no comparators are built and err is tied to 0.
//
// Timing (normal path): start sampled at edge 0, busy in cycles 1..W+1,
// done in cycle W+2, next request accepted earliest in cycle W+3.
// ============================================================================
module mont_mult_param #(
    parameter int W     = 64,
    parameter int CNT_W = 7
) (
    input  logic         pclk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         err
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_SUB  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]     state_q,  state_d;
    logic [W-1:0]   a_q,      a_d;       // shifts right; a_q[0] is the current bit
    logic [W-1:0]   b_q,      b_d;
    logic [W-1:0]   m_q,      m_d;
    logic [W+1:0]   p_q,      p_d;       // accumulator, invariant p < 2m
    logic [CNT_W-1:0] i_q,    i_d;
    logic [W-1:0]   result_q, result_d;

    // ------------------------------------------------------------------------
    // Operand check (optional)
    // ------------------------------------------------------------------------
    logic op_err;

`ifdef MONT_MOD_CHECK_EN
    logic err_q, err_d;

    assign op_err = ~m[0] | (a >= m) | (b >= m);

    // err is only refreshed when a request is accepted; a good request clears
    // it, so it reads 0 at the end of every normal operation.
    always_comb begin
        err_d = err_q;
        if ((state_q == ST_IDLE) && start) begin
            err_d = op_err;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign op_err = 1'b0;
    assign err    = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Datapath for one iteration
    //   q      = p[0] ^ (a_i & b[0])   makes the sum even
    //   sum    = p + a_i*b + q*m       formed at W+2 bits; p<2m, b<m, so sum<4m
    //   p_next = sum >> 1
    // ------------------------------------------------------------------------
    logic           a_bit;
    logic           q_bit;
    logic [W+1:0]   pp_b;
    logic [W+1:0]   pp_m;
    logic [W+1:0]   sum;
    logic [W+1:0]   p_next;

    assign a_bit = a_q[0];
    assign q_bit = p_q[0] ^ (a_bit & b_q[0]);

    // Partial products are plain AND masks of the latched operands.
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_pp
            assign pp_b[gi] = a_bit & b_q[gi];
            assign pp_m[gi] = q_bit & m_q[gi];
        end
    endgenerate
    assign pp_b[W+1:W] = 2'b00;
    assign pp_m[W+1:W] = 2'b00;

    assign sum    = p_q + pp_b + pp_m;
    assign p_next = sum >> 1;

    // ------------------------------------------------------------------------
    // Final reduction: p is in [0, 2m); one subtraction suffices. The true
    // difference is below m, so computing it at W bits is exact.
    // ------------------------------------------------------------------------
    logic           p_ge_m;
    logic [W-1:0]   p_minus_m;

    assign p_ge_m    = (p_q >= {2'b00, m_q});
    assign p_minus_m = p_q[W-1:0] - m_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        p_d      = p_q;
        i_d      = i_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d = a;
                    b_d = b;
                    m_d = m;
                    p_d = '0;
                    i_d = '0;
                    if (op_err) begin
                        // Rejected request: report immediately with a zero result.
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_ITER;
                    end
                end
            end

            ST_ITER: begin
                p_d = p_next;
                a_d = a_q >> 1;
                i_d = i_q + CNT_ONE;
                if (i_q == LAST_ITER) begin
                    state_d = ST_SUB;
                end
            end

            ST_SUB: begin
                result_d = p_ge_m ? p_minus_m : p_q[W-1:0];
                state_d  = ST_DONE;
            end

            ST_DONE: begin
                // A start seen here is deliberately dropped.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            p_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            p_q      <= p_d;
            i_q      <= i_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy   = (state_q == ST_ITER) || (state_q == ST_SUB);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mont_mult_param.sv
// ============================================================================
// tb_mont_mult_param
// Self-checking bench for mont_mult_param. Two instances share one clock:
// dut8 (W=8) and dut64 (W=64). Expected results are pushed onto a queue
// when a request is driven and popped when the design pulses done.
// Reference: reduce a*b mod m, then divide by 2 modulo m, W times.
// ============================================================================
module tb_mont_mult_param;

    typedef struct {
        logic [63:0] res;
        logic        err;
        int          lat;
        bit          chk;
    } exp_t;

    exp_t sb[$];

    logic        pclk = 1'b0;
    logic        reset;
    logic        start8, start64;
    logic [7:0]  a8, b8, m8;
    logic [63:0] a64, b64, m64;
    logic        busy8, done8, err8;
    logic        busy64, done64, err64;
    logic [7:0]  res8;
    logic [63:0] res64;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_done_cyc = 0;

    always #5 pclk = ~pclk;

    mont_mult_param #(.W(8), .CNT_W(4)) dut8 (
        .pclk(pclk), .reset(reset), .start(start8),
        .a(a8), .b(b8), .m(m8),
        .busy(busy8), .done(done8), .result(res8), .err(err8)
    );

    mont_mult_param #(.W(64), .CNT_W(7)) dut64 (
        .pclk(pclk), .reset(reset), .start(start64),
        .a(a64), .b(b64), .m(m64),
        .busy(busy64), .done(done64), .result(res64), .err(err64)
    );

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic tick;
        @(posedge pclk);
        #1;
        cyc++;
    endtask

    function automatic logic [63:0] mont_ref(input logic [63:0] av, input logic [63:0] bv,
                                              input logic [63:0] mv, input int w);
        logic [129:0] x;
        x = ({66'd0, av} * {66'd0, bv}) % {66'd0, mv};
        for (int k = 0; k < w; k++) begin
            if (x[0]) x = x + {66'd0, mv};
            x = x >> 1;
        end
        return x[63:0];
    endfunction

    task automatic drive(input bit big, input logic st, input logic [63:0] av,
                         input logic [63:0] bv, input logic [63:0] mv);
        if (big) begin
            start64 = st; a64 = av; b64 = bv; m64 = mv;
        end else begin
            start8 = st; a8 = av[7:0]; b8 = bv[7:0]; m8 = mv[7:0];
        end
    endtask

    function automatic logic get_done(input bit big);
        return big ? done64 : done8;
    endfunction

    function automatic logic get_busy(input bit big);
        return big ? busy64 : busy8;
    endfunction

    function automatic logic get_err(input bit big);
        return big ? err64 : err8;
    endfunction

    function automatic logic [63:0] get_res(input bit big);
        return big ? res64 : {56'd0, res8};
    endfunction

    // One operation: push expectation, pulse start, scramble inputs while
    // busy, pop and compare at done. poke>0 re-asserts start with a=2 in
    // that cycle (must be ignored).
    task automatic run_op(input bit big, input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] mv, input bit chk, input logic [63:0] exp_res,
                          input logic exp_err, input int poke);
        exp_t e;
        int   w;
        bit   got;
        w     = big ? 64 : 8;
        e.res = exp_res;
        e.err = exp_err;
        e.lat = exp_err ? 1 : w + 2;
        e.chk = chk;
        sb.push_back(e);
        drive(big, 1'b1, av, bv, mv);
        got = 0;
        for (int c = 1; c <= w + 10 && !got; c++) begin
            tick();
            if (c == poke) drive(big, 1'b1, 64'd2, bv, mv);
            else           drive(big, 1'b0, {$urandom, $urandom}, {$urandom, $urandom},
                                 {$urandom, $urandom});
            if (c == 1) begin
                tests++;
                if (get_busy(big) !== !exp_err) begin
                    fails++;
                    $display("FAIL busy_cycle1: got %0b expected %0b", get_busy(big), !exp_err);
                end
            end
            if (get_done(big) === 1'b1) begin
                got = 1;
                last_done_cyc = cyc;
                e = sb.pop_front();
                tests++;
                if (c !== e.lat) begin
                    fails++;
                    $display("FAIL latency: got %0d expected %0d", c, e.lat);
                end
                if (e.chk) begin
                    tests++;
                    if (get_res(big) !== e.res) begin
                        fails++;
                        $display("FAIL result a=%0h b=%0h m=%0h: got %0h expected %0h",
                                 av, bv, mv, get_res(big), e.res);
                    end
                end
                tests++;
                if (get_err(big) !== e.err) begin
                    fails++;
                    $display("FAIL err: got %0b expected %0b", get_err(big), e.err);
                end
                $display("[TB] op W=%0d a=%0h b=%0h m=%0h -> result=%0h err=%0b lat=%0d",
                         w, av, bv, mv, get_res(big), get_err(big), c);
            end
        end
        if (!got) begin
            tests++;
            fails++;
            void'(sb.pop_front());
            $display("FAIL done_timeout: got no done expected done within %0d cycles", w + 10);
        end
        // Cycle after DONE: back in IDLE, done must have dropped.
        tick();
        drive(big, 1'b0, 64'd0, 64'd0, 64'd0);
        tests++;
        if (get_done(big) !== 1'b0 || get_busy(big) !== 1'b0) begin
            fails++;
            $display("FAIL after_done: got done=%0b busy=%0b expected 0/0",
                     get_done(big), get_busy(big));
        end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset;
        reset = 1'b1;
        drive(0, 1'b1, 64'd5, 64'd7, 64'd13);
        drive(1, 1'b1, 64'd5, 64'd7, 64'd13);
        tick(); tick(); tick();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (get_busy(k[0]) !== 1'b0 || get_done(k[0]) !== 1'b0) begin
                fails++;
                $display("FAIL reset_flags dut%0d: got busy=%0b done=%0b expected 0/0",
                         k, get_busy(k[0]), get_done(k[0]));
            end
            tests++;
            if (get_res(k[0]) !== 64'd0 || get_err(k[0]) !== 1'b0) begin
                fails++;
                $display("FAIL reset_result dut%0d: got %0h/%0b expected 0/0",
                         k, get_res(k[0]), get_err(k[0]));
            end
        end
        drive(0, 1'b0, 64'd0, 64'd0, 64'd0);
        drive(1, 1'b0, 64'd0, 64'd0, 64'd0);
        reset = 1'b0;
        tick();
        $display("[TB] reset checked");
    endtask

    task automatic test_basic;
        run_op(0, 64'd5, 64'd7, 64'd13, 1, 64'd1, 1'b0, 0);
        run_op(0, 64'd1, 64'd1, 64'd13, 1, 64'd3, 1'b0, 0);
        run_op(0, 64'd0, 64'd9, 64'd13, 1, 64'd0, 1'b0, 0);
        run_op(0, 64'd12, 64'd12, 64'd13, 1, mont_ref(64'd12, 64'd12, 64'd13, 8), 1'b0, 0);
    endtask

    task automatic test_wide;
        run_op(1, 64'd59, 64'd59, 64'hFFFF_FFFF_FFFF_FFC5, 1, 64'd59, 1'b0, 0);
    endtask

    task automatic test_ignore_start;
        // start with a=2 in cycle 4 is ignored
        run_op(0, 64'd5, 64'd7, 64'd13, 1, 64'd1, 1'b0, 4);
        // start raised during DONE (cycle 10) is ignored; then a fresh start
        run_op(0, 64'd2, 64'd7, 64'd13, 1, mont_ref(64'd2, 64'd7, 64'd13, 8), 1'b0, 10);
        run_op(0, 64'd11, 64'd4, 64'd13, 1, mont_ref(64'd11, 64'd4, 64'd13, 8), 1'b0, 0);
    endtask

    task automatic test_back_to_back;
        int t0;
        run_op(0, 64'd3, 64'd8, 64'd11, 1, mont_ref(64'd3, 64'd8, 64'd11, 8), 1'b0, 0);
        t0 = last_done_cyc;
        run_op(0, 64'd9, 64'd10, 64'd11, 1, mont_ref(64'd9, 64'd10, 64'd11, 8), 1'b0, 0);
        tests++;
        if (last_done_cyc - t0 !== 11) begin
            fails++;
            $display("FAIL throughput: got %0d cycles expected 11", last_done_cyc - t0);
        end
    endtask

    task automatic test_reset_mid_op;
        bit saw_done;
        drive(0, 1'b1, 64'd5, 64'd7, 64'd13);
        tick();
        drive(0, 1'b0, 64'd5, 64'd7, 64'd13);
        for (int c = 2; c <= 5; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || res8 !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_op: got busy=%0b done=%0b result=%0h expected 0/0/0",
                     busy8, done8, res8);
        end
        saw_done = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (done8 === 1'b1) saw_done = 1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL no_done_after_abort: got done pulse expected none");
        end
        $display("[TB] reset mid-operation checked");
        run_op(0, 64'd5, 64'd7, 64'd13, 1, 64'd1, 1'b0, 0);
    endtask

    task automatic test_random;
        logic [63:0] av, bv, mv;
        for (int k = 0; k < 8; k++) begin
            mv = 64'($urandom_range(3, 255)) | 64'd1;
            av = 64'($urandom) % mv;
            bv = 64'($urandom) % mv;
            run_op(0, av, bv, mv, 1, mont_ref(av, bv, mv, 8), 1'b0, 0);
        end
        for (int k = 0; k < 3; k++) begin
            mv = {$urandom, $urandom} | 64'd1;
            av = {$urandom, $urandom} % mv;
            bv = {$urandom, $urandom} % mv;
            run_op(1, av, bv, mv, 1, mont_ref(av, bv, mv, 64), 1'b0, 0);
        end
    endtask

    task automatic test_check;
`ifdef MONT_MOD_CHECK_EN
        run_op(0, 64'd5, 64'd7, 64'd12, 1, 64'd0, 1'b1, 0);
        run_op(0, 64'd13, 64'd1, 64'd13, 1, 64'd0, 1'b1, 0);
        run_op(0, 64'd1, 64'd13, 64'd13, 1, 64'd0, 1'b1, 0);
        run_op(0, 64'd5, 64'd7, 64'd13, 1, 64'd1, 1'b0, 0);
`else
        // Without checking an even modulus still runs the full path, err=0.
        run_op(0, 64'd5, 64'd7, 64'd12, 0, 64'd0, 1'b0, 0);
        run_op(0, 64'd13, 64'd1, 64'd13, 0, 64'd0, 1'b0, 0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 64'd0, 64'd0, 64'd0);
        drive(1, 1'b0, 64'd0, 64'd0, 64'd0);
        test_reset();
        test_basic();
        test_wide();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        test_check();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
